// File: rtl/reg_native_arb_pkg.sv
// rtl/reg_native_arb_pkg.sv - shared state encoding and width helpers for reg_native_arb
//
// Contents:
//    arb_state_e - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//    cnt_width   - width of a counter that must hold 0..timeout
//    idx_width   - width of an index into n requesters (at least 1 bit)
package reg_native_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_native_arb_rr_pick.sv
// rtl/reg_native_arb_rr_pick.sv - combinational rotate-priority requester select
//
// Ports:
//    req_i     - request vector, one bit per requester
//    ptr_i     - index of the last granted requester; search starts at ptr_i+1
//    gnt_o     - one-hot grant (all zero when req_i is zero)
//    gnt_idx_o - binary index of the granted requester (0 when req_i is zero)
module rr_pick
   import reg_native_arb_pkg::*;
#(
   parameter  int N_REQ = 2,
   localparam int IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IW-1:0]    gnt_idx_o
);

   logic          found;
   logic [IW-1:0] cand;

   // Walk ptr+1, ptr+2, ... wrapping modulo N_REQ; the pointer itself is
   // visited last so the previous winner has lowest priority.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IW'((int'(ptr_i) + k) % N_REQ);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            gnt_idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/reg_native_arb.sv
// rtl/reg_native_arb.sv - round-robin arbiter sharing one reg_native target between N_REQ requesters
//
// Ports:
//    clk, rst_n         - clock, asynchronous active-low reset
//    s_req_vld          - per-requester request, held until its s_ack_vld bit
//    s_wr_en, s_rd_en   - per-requester access type
//    s_addr, s_wr_data  - flattened per-requester address / write data (slice i = requester i)
//    s_ack_vld          - one-hot completion pulse to the granted requester
//    s_rd_data, s_err   - response data / error, qualified by s_ack_vld
//    m_req_vld          - single-cycle request pulse to the target
//    m_wr_en, m_rd_en   - access type to the target, stable from ISSUE through WAIT
//    m_addr, m_wr_data  - address / write data to the target, stable from ISSUE through WAIT
//    m_ack_vld          - target completion pulse (honoured only in WAIT)
//    m_rd_data          - target read data, valid with m_ack_vld
//    busy               - high whenever the FSM is not IDLE
module reg_native_arb
   import reg_native_arb_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int TIMEOUT    = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              s_req_vld,
   input  logic [N_REQ-1:0]              s_wr_en,
   input  logic [N_REQ-1:0]              s_rd_en,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   s_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0]   s_wr_data,
   output logic [N_REQ-1:0]              s_ack_vld,
   output logic [DATA_WIDTH-1:0]         s_rd_data,
   output logic                          s_err,
   output logic                          m_req_vld,
   output logic                          m_wr_en,
   output logic                          m_rd_en,
   output logic [ADDR_WIDTH-1:0]         m_addr,
   output logic [DATA_WIDTH-1:0]         m_wr_data,
   input  logic                          m_ack_vld,
   input  logic [DATA_WIDTH-1:0]         m_rd_data,
   output logic                          busy
);

   localparam int            IW        = idx_width(N_REQ);
   localparam int            CW        = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [IW-1:0] PTR_RST   = IW'(N_REQ - 1);

   arb_state_e              state_q, state_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [IW-1:0]           gnt_q, gnt_d;
   logic [CW-1:0]           cnt_q, cnt_d;

   // The m_* registers double as the latched copy of the granted transaction.
   logic                    m_req_vld_q, m_req_vld_d;
   logic                    m_wr_en_q, m_wr_en_d;
   logic                    m_rd_en_q, m_rd_en_d;
   logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0]   m_wr_data_q, m_wr_data_d;

   logic [N_REQ-1:0]        s_ack_vld_q, s_ack_vld_d;
   logic [DATA_WIDTH-1:0]   s_rd_data_q, s_rd_data_d;
   logic                    s_err_q, s_err_d;
   logic                    busy_q, busy_d;

   logic [N_REQ-1:0]        pick_gnt;
   logic [IW-1:0]           pick_idx;
   logic                    win_wr;
   logic                    win_rd;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [DATA_WIDTH-1:0]   win_wdata;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req_i     (s_req_vld),
      .ptr_i     (ptr_q),
      .gnt_o     (pick_gnt),
      .gnt_idx_o (pick_idx)
   );

   assign win_wr    = s_wr_en[pick_idx];
   assign win_rd    = s_rd_en[pick_idx];
   assign win_addr  = s_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_wdata = s_wr_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      m_req_vld_d = 1'b0;
      m_wr_en_d   = 1'b0;
      m_rd_en_d   = 1'b0;
      m_addr_d    = '0;
      m_wr_data_d = '0;
      s_ack_vld_d = '0;
      s_rd_data_d = '0;
      s_err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|s_req_vld) begin
               ptr_d = pick_idx;
               gnt_d = pick_idx;
               if (win_wr || win_rd) begin
                  state_d     = ISSUE;
                  m_req_vld_d = 1'b1;
                  m_wr_en_d   = win_wr;
                  m_rd_en_d   = win_rd;
                  m_addr_d    = win_addr;
                  m_wr_data_d = win_wdata;
               end else begin
                  // Neither read nor write: nothing to send downstream,
                  // complete straight away with an error.
                  state_d     = RESP;
                  s_ack_vld_d = pick_gnt;
                  s_err_d     = 1'b1;
               end
            end
         end

         ISSUE: begin
            state_d     = WAIT;
            cnt_d       = '0;
            m_wr_en_d   = m_wr_en_q;
            m_rd_en_d   = m_rd_en_q;
            m_addr_d    = m_addr_q;
            m_wr_data_d = m_wr_data_q;
         end

         WAIT: begin
            if (m_ack_vld) begin
               state_d            = RESP;
               s_ack_vld_d[gnt_q] = 1'b1;
               s_rd_data_d        = m_rd_en_q ? m_rd_data : '0;
            end else if (cnt_q == CNT_LIMIT) begin
               // cnt_q counts WAIT cycles already spent without an ack; the
               // cycle in which it reaches TIMEOUT is the last chance for an
               // ack, so the window is TIMEOUT+1 WAIT cycles long.
               state_d            = RESP;
               s_ack_vld_d[gnt_q] = 1'b1;
               s_err_d            = 1'b1;
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               m_wr_en_d   = m_wr_en_q;
               m_rd_en_d   = m_rd_en_q;
               m_addr_d    = m_addr_q;
               m_wr_data_d = m_wr_data_q;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= PTR_RST;
         gnt_q       <= '0;
         cnt_q       <= '0;
         m_req_vld_q <= 1'b0;
         m_wr_en_q   <= 1'b0;
         m_rd_en_q   <= 1'b0;
         m_addr_q    <= '0;
         m_wr_data_q <= '0;
         s_ack_vld_q <= '0;
         s_rd_data_q <= '0;
         s_err_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         m_req_vld_q <= m_req_vld_d;
         m_wr_en_q   <= m_wr_en_d;
         m_rd_en_q   <= m_rd_en_d;
         m_addr_q    <= m_addr_d;
         m_wr_data_q <= m_wr_data_d;
         s_ack_vld_q <= s_ack_vld_d;
         s_rd_data_q <= s_rd_data_d;
         s_err_q     <= s_err_d;
         busy_q      <= busy_d;
      end
   end

   assign m_req_vld = m_req_vld_q;
   assign m_wr_en   = m_wr_en_q;
   assign m_rd_en   = m_rd_en_q;
   assign m_addr    = m_addr_q;
   assign m_wr_data = m_wr_data_q;
   assign s_ack_vld = s_ack_vld_q;
   assign s_rd_data = s_rd_data_q;
   assign s_err     = s_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_reg_native_arb.sv
// tb/tb_reg_native_arb.sv - self-checking bench for reg_native_arb with a behavioural target and reference model
module tb_reg_native_arb;

   localparam int NR = 2;
   localparam int DW = 32;
   localparam int AW = 6;
   localparam int TO = 8;

   typedef struct {
      bit          wr;
      bit          rd;
      logic [5:0]  addr;
      logic [31:0] data;
   } op_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NR-1:0]      s_req_vld, s_wr_en, s_rd_en;
   logic [NR*AW-1:0]   s_addr;
   logic [NR*DW-1:0]   s_wr_data;
   logic [NR-1:0]      s_ack_vld;
   logic [DW-1:0]      s_rd_data;
   logic               s_err;
   logic               m_req_vld, m_wr_en, m_rd_en;
   logic [AW-1:0]      m_addr;
   logic [DW-1:0]      m_wr_data;
   logic               m_ack_vld = 1'b0;
   logic [DW-1:0]      m_rd_data = '0;
   logic               busy;

   reg_native_arb #(
      .N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_req_vld(s_req_vld), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
      .s_addr(s_addr), .s_wr_data(s_wr_data),
      .s_ack_vld(s_ack_vld), .s_rd_data(s_rd_data), .s_err(s_err),
      .m_req_vld(m_req_vld), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
      .m_addr(m_addr), .m_wr_data(m_wr_data),
      .m_ack_vld(m_ack_vld), .m_rd_data(m_rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // ext_mem-style target: registered inputs, one-cycle ack, registered read
   // data (pre-write value when read and write coincide). dbg_err silences it.
   logic [31:0] tgt_mem [64] = '{default: 32'h0};
   logic        t_vld = 1'b0, t_wr = 1'b0;
   logic [5:0]  t_addr = '0;
   logic [31:0] t_wdata = '0;
   logic        dbg_err;

   always @(posedge clk) begin
      t_vld     <= m_req_vld;
      t_wr      <= m_wr_en;
      t_addr    <= m_addr;
      t_wdata   <= m_wr_data;
      m_ack_vld <= 1'b0;
      if (t_vld && !dbg_err) begin
         m_ack_vld <= 1'b1;
         m_rd_data <= tgt_mem[t_addr];
         if (t_wr) tgt_mem[t_addr] <= t_wdata;
      end
   end

   // Reference model state
   logic [31:0] ref_mem [64];
   int          last_g;
   logic [31:0] last_rd [NR];
   op_t         ops [NR][8];
   int          n_ops [NR];
   int          head [NR];
   int          g_hist [$];
   int          n_pass = 0;
   int          n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Expected response from the spec rules, applied to the reference memory.
   task automatic model_resp(input op_t op, output logic [31:0] d, output logic e);
      if (!op.wr && !op.rd) begin
         d = '0; e = 1'b1;
      end else begin
         d = op.rd ? ref_mem[op.addr] : 32'h0;
         e = 1'b0;
         if (op.wr) ref_mem[op.addr] = op.data;
      end
   endtask

   task automatic single(input int idx, input bit wr, input bit rd,
                         input logic [5:0] addr, input logic [31:0] data, input string tag);
      int t_req, t_ack, nreq, exp_lat, exp_treq;
      logic [31:0] exp_d, rd_s;
      logic exp_e, err_s;
      logic [1:0] exp_v, ack_s;
      op_t op;
      t_req = -1; t_ack = -1; nreq = 0; ack_s = '0; rd_s = '0; err_s = 1'b0;
      exp_v = '0; exp_v[idx] = 1'b1;
      op.wr = wr; op.rd = rd; op.addr = addr; op.data = data;
      if (!wr && !rd) begin
         exp_d = '0; exp_e = 1'b1; exp_lat = 1; exp_treq = -1;
      end else if (dbg_err) begin
         exp_d = '0; exp_e = 1'b1; exp_lat = TO + 3; exp_treq = 1;
      end else begin
         model_resp(op, exp_d, exp_e); exp_lat = 4; exp_treq = 1;
      end
      @(posedge clk); #1;
      s_req_vld[idx] = 1'b1; s_wr_en[idx] = wr; s_rd_en[idx] = rd;
      s_addr[idx*AW +: AW] = addr; s_wr_data[idx*DW +: DW] = data;
      for (int c = 0; c < TO + 20; c++) begin
         @(negedge clk);
         if (m_req_vld) begin
            nreq++;
            if (t_req < 0) t_req = c;
         end
         if (s_ack_vld != '0) begin
            t_ack = c; ack_s = s_ack_vld; rd_s = s_rd_data; err_s = s_err;
            break;
         end
      end
      @(posedge clk); #1;
      s_req_vld[idx] = 1'b0; s_wr_en[idx] = 1'b0; s_rd_en[idx] = 1'b0;
      last_g = idx; last_rd[idx] = rd_s;
      chk({tag, "_lat"}, 64'(t_ack), 64'(exp_lat));
      chk({tag, "_mreq_at"}, 64'(t_req), 64'(exp_treq));
      chk({tag, "_mreq_cnt"}, 64'(nreq), 64'((exp_treq < 0) ? 0 : 1));
      chk({tag, "_ackvec"}, 64'(ack_s), 64'(exp_v));
      chk({tag, "_rdata"}, 64'(rd_s), 64'(exp_d));
      chk({tag, "_err"}, 64'(err_s), 64'(exp_e));
   endtask

   task automatic drive_slot(input int i);
      if (head[i] < n_ops[i]) begin
         s_req_vld[i] = 1'b1;
         s_wr_en[i]   = ops[i][head[i]].wr;
         s_rd_en[i]   = ops[i][head[i]].rd;
         s_addr[i*AW +: AW]    = ops[i][head[i]].addr;
         s_wr_data[i*DW +: DW] = ops[i][head[i]].data;
      end else begin
         s_req_vld[i] = 1'b0; s_wr_en[i] = 1'b0; s_rd_en[i] = 1'b0;
      end
   endtask

   // Requesters with queued ops keep requesting; each ack is checked against
   // the round-robin rule and the reference memory, then the next op is posted.
   task automatic run_phase(input string tag, input int budget);
      int cyc, g;
      logic [31:0] exp_d;
      logic exp_e;
      logic [1:0] exp_v;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) drive_slot(i);
      cyc = 0;
      while ((head[0] < n_ops[0] || head[1] < n_ops[1]) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (s_ack_vld != '0) begin
            g = -1;
            for (int k = 1; k <= NR; k++)
               if (g < 0 && head[(last_g + k) % NR] < n_ops[(last_g + k) % NR]) g = (last_g + k) % NR;
            exp_v = '0; exp_v[g] = 1'b1;
            model_resp(ops[g][head[g]], exp_d, exp_e);
            chk({tag, "_ackvec"}, 64'(s_ack_vld), 64'(exp_v));
            chk({tag, "_rdata"}, 64'(s_rd_data), 64'(exp_d));
            chk({tag, "_err"}, 64'(s_err), 64'(exp_e));
            if (s_ack_vld[g]) last_rd[g] = s_rd_data;
            g_hist.push_back(g);
            last_g = g;
            head[g]++;
            @(posedge clk); #1;
            drive_slot(g);
         end
      end
      chk({tag, "_done"}, 64'(head[0] + head[1]), 64'(n_ops[0] + n_ops[1]));
      for (int i = 0; i < NR; i++) begin
         s_req_vld[i] = 1'b0; s_wr_en[i] = 1'b0; s_rd_en[i] = 1'b0;
      end
   endtask

   task automatic set_op(input int i, input int j, input bit wr, input bit rd,
                         input logic [5:0] a, input logic [31:0] d);
      ops[i][j].wr = wr; ops[i][j].rd = rd; ops[i][j].addr = a; ops[i][j].data = d;
   endtask

   initial begin
      rst_n = 1'b0; dbg_err = 1'b0;
      s_req_vld = '0; s_wr_en = '0; s_rd_en = '0; s_addr = '0; s_wr_data = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
      last_g = NR - 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_m_req", 64'(m_req_vld), 64'(0));
      chk("rst_s_ack", 64'(s_ack_vld), 64'(0));
      chk("rst_m_addr", 64'(m_addr), 64'(0));
      chk("rst_s_err", 64'(s_err), 64'(0));
      rst_n = 1'b1;

      single(0, 1'b1, 1'b0, 6'h05, 32'hDEADBEEF, "wr0");
      single(0, 1'b0, 1'b1, 6'h05, 32'h0, "rd0");
      chk("rd0_value", 64'(last_rd[0]), 64'h0000_0000_DEAD_BEEF);

      single(1, 1'b0, 1'b0, 6'h07, 32'h0, "noop");

      dbg_err = 1'b1;
      single(0, 1'b0, 1'b1, 6'h10, 32'h0, "tmo");
      dbg_err = 1'b0;
      single(1, 1'b0, 1'b1, 6'h05, 32'h0, "post_tmo");
      chk("post_tmo_value", 64'(last_rd[1]), 64'h0000_0000_DEAD_BEEF);
      single(1, 1'b1, 1'b0, 6'h10, 32'h1234_5678, "wr10");

      // Contention: grant order 0, 1, 0 with each requester's own data
      g_hist.delete();
      n_ops[0] = 2; n_ops[1] = 1; head[0] = 0; head[1] = 0;
      set_op(0, 0, 1'b0, 1'b1, 6'h05, 32'h0);
      set_op(0, 1, 1'b0, 1'b1, 6'h06, 32'h0);
      set_op(1, 0, 1'b0, 1'b1, 6'h10, 32'h0);
      run_phase("cont", 200);
      chk("cont_g0", 64'(g_hist.size() > 0 ? g_hist[0] : -1), 64'(0));
      chk("cont_g1", 64'(g_hist.size() > 1 ? g_hist[1] : -1), 64'(1));
      chk("cont_g2", 64'(g_hist.size() > 2 ? g_hist[2] : -1), 64'(0));
      chk("cont_rd1", 64'(last_rd[1]), 64'h0000_0000_1234_5678);

      // Write by 0 then read by 1 of the same address, back to back
      single(1, 1'b0, 1'b1, 6'h06, 32'h0, "pre_wr");
      n_ops[0] = 1; n_ops[1] = 1; head[0] = 0; head[1] = 0;
      set_op(0, 0, 1'b1, 1'b0, 6'h3F, 32'hA5A5A5A5);
      set_op(1, 0, 1'b0, 1'b1, 6'h3F, 32'h0);
      run_phase("wr_rd", 200);
      chk("wr_rd_value", 64'(last_rd[1]), 64'h0000_0000_A5A5_A5A5);

      // Reset during WAIT: immediate zero outputs, late ack ignored
      @(posedge clk); #1;
      s_req_vld = 2'b01; s_rd_en = 2'b01; s_addr[AW-1:0] = 6'h3F;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_busy", 64'(busy), 64'(1));
      rst_n = 1'b0; s_req_vld = '0; s_rd_en = '0;
      #1;
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_m_addr", 64'(m_addr), 64'(0));
      chk("arst_m_rd_en", 64'(m_rd_en), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_g = NR - 1;
      chk("late_ack_seen", 64'(m_ack_vld), 64'(1));
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_no_ack", 64'(s_ack_vld), 64'(0));
         chk("post_rst_idle", 64'({busy, m_req_vld, s_err}), 64'(0));
         chk("post_rst_rdata", 64'(s_rd_data), 64'(0));
      end
      single(0, 1'b0, 1'b1, 6'h3F, 32'h0, "rst_rd");
      chk("rst_rd_value", 64'(last_rd[0]), 64'h0000_0000_A5A5_A5A5);

      // Randomised mixed traffic on a small address window
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NR; i++) begin
            n_ops[i] = $urandom_range(3, 8); head[i] = 0;
            for (int j = 0; j < n_ops[i]; j++) begin
               int kind;
               kind = $urandom_range(0, 3);
               set_op(i, j, kind[1], kind[0] | (kind == 0 ? 1'b0 : 1'b0),
                      6'($urandom_range(0, 7)), $urandom);
            end
         end
         run_phase("rand", 1000);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
